// File: rtl/palindrome_gen.sv
// Serial palindrome generator: takes an H-bit seed, mirrors it into an N-bit
// palindrome over H cycles, then streams the word MSB-first under valid/ready.

module palindrome_gen_cell (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic wr,
    input  logic d,
    output logic q
);
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)   q <= 1'b0;
        else if (clr) q <= 1'b0;
        else if (wr)  q <= d;
    end
endmodule

module palindrome_gen #(
    parameter int N = 9
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [(N+1)/2-1:0] seed,
    output logic [N-1:0] word,
    output logic         word_valid,
    output logic         ser_bit,
    output logic         ser_valid,
    input  logic         ser_ready,
    output logic         ser_last
);
    localparam int H  = (N + 1) / 2;
    localparam int CW = $clog2(N + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BUILD = 2'd1,
        SEND  = 2'd2
    } state_t;

    state_t         state;
    logic [H-1:0]   seed_r;
    logic [CW-1:0]  cnt;      // k while building, idx while sending
    logic           accept;
    logic           mbit;
    logic           sbit;
    logic [N-1:0]   wr;

    assign accept = in_ready && in_valid;

    always_comb begin
        mbit = 1'b0;
        for (int j = 0; j < H; j++)
            if (cnt == CW'(j)) mbit = seed_r[j];
    end

    // Each word bit is owned by one cell; a BUILD step hits both mirror positions.
    for (genvar i = 0; i < N; i++) begin : g_bit
        assign wr[i] = (state == BUILD) &&
                       ((cnt == CW'(i)) || (cnt == CW'(N - 1 - i)));
        palindrome_gen_cell u_cell (
            .clk  (clk),
            .rst_n(rst_n),
            .clr  (accept),
            .wr   (wr[i]),
            .d    (mbit),
            .q    (word[i])
        );
    end

    always_comb begin
        sbit = 1'b0;
        for (int i = 0; i < N; i++)
            if (cnt == CW'(N - 1 - i)) sbit = word[i];
    end

    // Serial bit is gated by the registered valid so it reads 0 outside SEND.
    assign ser_bit = ser_valid & sbit;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            seed_r     <= '0;
            cnt        <= '0;
            in_ready   <= 1'b1;
            word_valid <= 1'b0;
            ser_valid  <= 1'b0;
            ser_last   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        seed_r   <= seed;
                        cnt      <= '0;
                        state    <= BUILD;
                        in_ready <= 1'b0;
                    end
                end
                BUILD: begin
                    if (cnt == CW'(H - 1)) begin
                        state      <= SEND;
                        cnt        <= '0;
                        word_valid <= 1'b1;
                        ser_valid  <= 1'b1;
                        ser_last   <= 1'b0;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                SEND: begin
                    if (ser_ready) begin
                        if (ser_last) begin
                            state      <= IDLE;
                            cnt        <= '0;
                            in_ready   <= 1'b1;
                            word_valid <= 1'b0;
                            ser_valid  <= 1'b0;
                            ser_last   <= 1'b0;
                        end else begin
                            cnt      <= cnt + CW'(1);
                            ser_last <= (cnt == CW'(N - 2));
                        end
                    end
                end
                default: begin
                    state      <= IDLE;
                    cnt        <= '0;
                    in_ready   <= 1'b1;
                    word_valid <= 1'b0;
                    ser_valid  <= 1'b0;
                    ser_last   <= 1'b0;
                end
            endcase
        end
    end
endmodule
